// File: rtl/bkm_bus_regfile.sv
// Monitor-bus slave exposing NUM_REGS byte registers at BASE_ADDR, with auto-increment,
// local write port, maskable IRQ status and slot-mode gating. Optional: BKM_BUS_TIMEOUT_EN.
module bkm_bus_regfile #(
    parameter int          NUM_REGS       = 8,
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter logic [7:0]  CARD_ID        = 8'h68,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         IW             = $clog2(NUM_REGS)
) (
    input  logic                  clk_20mhz,
    input  logic                  reset_x,
    input  logic                  slot_x_int_x,
    input  logic                  clk_rw,
    input  logic                  ax_d,
    input  logic                  r_wx,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe_x,
    output logic                  int_x,
    output logic                  int_oe_x,
    input  logic                  loc_wr_en,
    input  logic [IW-1:0]         loc_wr_idx,
    input  logic [7:0]            loc_wr_data,
    input  logic [7:0]            irq_set,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  bus_wr_pulse,
    output logic [IW-1:0]         bus_wr_idx,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    if (NUM_REGS < 4 || NUM_REGS > 64 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("bkm_bus_regfile: parameter out of range");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_s_d;
    logic [7:0]              r_addr;
    logic [7:0]              r_regs [NUM_REGS];
    logic [7:0]              r_data_out;
    logic                    r_data_oe_x;
    logic [7:0]              r_presented;
    logic [7:0]              r_rd_set;
    logic                    r_rd_hit;
    logic [IW-1:0]           r_rd_idx;
    logic                    r_int_x;
    logic                    r_bus_wr_pulse;
    logic [IW-1:0]           r_bus_wr_idx;

    logic                    w_s, w_rise, w_fall;
    logic [7:0]              w_idx;
    logic [IW-1:0]           w_ridx;
    logic                    w_hit;
    logic                    w_busy;
    logic                    w_timeout;
    logic                    w_addr_cap, w_wr_commit, w_rd_start;
    logic                    w_data_end, w_rd_end, w_clr;
    logic                    w_loc_ok;
    logic [7:0]              w_addr_inc;
    logic [7:0]              w_rd_val;
    logic [7:0]              w_status_nxt;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // Window test in 8 bits: addresses below BASE_ADDR wrap to large indices and miss.
    assign w_idx  = r_addr - BASE_ADDR;
    assign w_ridx = w_idx[IW-1:0];
    assign w_hit  = (w_idx < 8'(NUM_REGS));
    assign w_busy = (r_state == ST_ADDR) || (r_state == ST_WRITE) || (r_state == ST_READ);

`ifdef BKM_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk_20mhz) begin
        if (!reset_x) begin
            r_to_cnt <= '0;
        end else if (w_busy && !slot_x_int_x) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    assign w_timeout = w_busy && !slot_x_int_x && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_rise) w_state_nxt = ax_d ? ST_ADDR : (r_wx ? ST_READ : ST_WRITE);
            ST_ADDR,
            ST_WRITE,
            ST_READ:  if (w_fall) w_state_nxt = ST_IDLE;
            ST_WAIT:  if (!w_s) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) w_state_nxt = ST_WAIT;
        if (slot_x_int_x) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_20mhz) begin
        if (!reset_x) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    assign w_addr_cap  = (r_state == ST_IDLE) && w_rise && ax_d && !slot_x_int_x;
    assign w_wr_commit = (r_state == ST_IDLE) && w_rise && !ax_d && !r_wx && w_hit
                         && (w_idx >= 8'd2) && !slot_x_int_x;
    assign w_rd_start  = (r_state == ST_IDLE) && w_rise && !ax_d && r_wx && !slot_x_int_x;
    assign w_data_end  = ((r_state == ST_WRITE) || (r_state == ST_READ)) && w_fall
                         && !slot_x_int_x && !w_timeout;
    assign w_rd_end    = (r_state == ST_READ) && w_fall && !slot_x_int_x && !w_timeout;
    assign w_clr       = w_rd_end && r_rd_hit && (r_rd_idx == IW'(1));

    assign w_addr_inc  = (w_hit && (w_idx == 8'(NUM_REGS - 1))) ? BASE_ADDR : r_addr + 8'd1;
    assign w_rd_val    = (w_idx == 8'd0) ? CARD_ID : r_regs[w_ridx];
    assign w_loc_ok    = loc_wr_en && (loc_wr_idx >= IW'(2)) && (int'(loc_wr_idx) < NUM_REGS);

    // Bits raised while the read was in flight must not be lost by the clear.
    always_comb begin
        w_status_nxt = r_regs[1] | irq_set;
        if (w_clr)     w_status_nxt = (r_regs[1] & ~r_presented) | irq_set | r_rd_set;
        if (w_timeout) w_status_nxt = w_status_nxt | 8'h80;
    end

    always_ff @(posedge clk_20mhz) begin
        if (!reset_x) begin
            r_sync         <= '0;
            r_s_d          <= 1'b0;
            r_addr         <= 8'h00;
            r_data_out     <= 8'h00;
            r_data_oe_x    <= 1'b1;
            r_presented    <= 8'h00;
            r_rd_set       <= 8'h00;
            r_rd_hit       <= 1'b0;
            r_rd_idx       <= '0;
            r_int_x        <= 1'b1;
            r_bus_wr_pulse <= 1'b0;
            r_bus_wr_idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
        end else begin
            r_sync         <= {r_sync[SYNC_STAGES-2:0], clk_rw};
            r_s_d          <= w_s;
            r_bus_wr_pulse <= w_wr_commit;
            if (w_wr_commit) r_bus_wr_idx <= w_ridx;

            if (w_addr_cap)      r_addr <= data_in;
            else if (w_data_end) r_addr <= w_addr_inc;

            // A bus commit to the same index in the same cycle beats the local port.
            for (int i = 2; i < NUM_REGS; i++) begin
                if (w_wr_commit && (w_ridx == IW'(i)))     r_regs[i] <= data_in;
                else if (w_loc_ok && (loc_wr_idx == IW'(i))) r_regs[i] <= loc_wr_data;
            end
            r_regs[1] <= w_status_nxt;

            if (w_rd_start) begin
                r_rd_set <= 8'h00;
                r_rd_hit <= w_hit;
                r_rd_idx <= w_ridx;
                if (w_hit) begin
                    r_data_out  <= w_rd_val;
                    r_presented <= w_rd_val;
                    r_data_oe_x <= 1'b0;
                end
            end else if (r_state == ST_READ) begin
                r_rd_set <= r_rd_set | irq_set;
            end
            if (w_rd_end || w_timeout || slot_x_int_x) r_data_oe_x <= 1'b1;

            r_int_x <= slot_x_int_x | ~|(r_regs[1] & r_regs[2]);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = r_regs[g];
    end

    assign data_out     = r_data_out;
    assign data_oe_x    = r_data_oe_x | slot_x_int_x;
    assign int_x        = r_int_x;
    assign int_oe_x     = r_int_x;
    assign bus_wr_pulse = r_bus_wr_pulse;
    assign bus_wr_idx   = r_bus_wr_idx;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_bkm_bus_regfile.sv
// Directed bench for bkm_bus_regfile (default parameters); write pulses checked by a scoreboard.
module tb_bkm_bus_regfile;

    logic        clk_20mhz = 1'b0;
    logic        reset_x;
    logic        slot_x_int_x;
    logic        clk_rw;
    logic        ax_d;
    logic        r_wx;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe_x;
    logic        int_x;
    logic        int_oe_x;
    logic        loc_wr_en;
    logic [2:0]  loc_wr_idx;
    logic [7:0]  loc_wr_data;
    logic [7:0]  irq_set;
    logic [63:0] regs_flat;
    logic        bus_wr_pulse;
    logic [2:0]  bus_wr_idx;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rd;
    logic       oe_lo;

    bkm_bus_regfile dut (
        .clk_20mhz    (clk_20mhz),
        .reset_x      (reset_x),
        .slot_x_int_x (slot_x_int_x),
        .clk_rw       (clk_rw),
        .ax_d         (ax_d),
        .r_wx         (r_wx),
        .data_in      (data_in),
        .data_out     (data_out),
        .data_oe_x    (data_oe_x),
        .int_x        (int_x),
        .int_oe_x     (int_oe_x),
        .loc_wr_en    (loc_wr_en),
        .loc_wr_idx   (loc_wr_idx),
        .loc_wr_data  (loc_wr_data),
        .irq_set      (irq_set),
        .regs_flat    (regs_flat),
        .bus_wr_pulse (bus_wr_pulse),
        .bus_wr_idx   (bus_wr_idx),
        .dbg_state    (dbg_state)
    );

    always #25 clk_20mhz = ~clk_20mhz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the next expected index.
    always @(negedge clk_20mhz) begin
        if (reset_x && bus_wr_pulse) begin
            if (exp_q.size() == 0) check("wr_unexpected", {61'd0, bus_wr_idx}, 64'hFF);
            else                   check("wr_idx", {61'd0, bus_wr_idx}, {56'd0, exp_q.pop_front()});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_20mhz);
    endtask

    // One strobe: hold high for 'hold' clocks; at cycle ev_at pulse irq_set and/or loc_wr_en.
    task automatic bus_xfer(input logic ax, input logic rw, input logic [7:0] din, input int hold,
                            input int ev_at, input logic [7:0] ev_irq, input logic ev_loc,
                            output logic [7:0] rdat, output logic oe);
        @(negedge clk_20mhz);
        ax_d = ax; r_wx = rw; data_in = din; clk_rw = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i == ev_at) begin
                irq_set   = ev_irq;
                loc_wr_en = ev_loc;
            end
            @(negedge clk_20mhz);
            irq_set   = 8'h00;
            loc_wr_en = 1'b0;
        end
        rdat = data_out;
        oe   = ~data_oe_x;
        clk_rw = 1'b0;
        wait_cyc(6);
    endtask

    task automatic bus_addr(input logic [7:0] a);
        logic [7:0] d; logic o;
        bus_xfer(1'b1, 1'b0, a, 6, -1, 8'h00, 1'b0, d, o);
    endtask

    task automatic bus_write(input logic [7:0] v);
        logic [7:0] d; logic o;
        bus_xfer(1'b0, 1'b0, v, 6, -1, 8'h00, 1'b0, d, o);
    endtask

    task automatic bus_read(output logic [7:0] d, output logic o);
        bus_xfer(1'b0, 1'b1, 8'h00, 6, -1, 8'h00, 1'b0, d, o);
    endtask

    task automatic loc_wr(input logic [2:0] idx, input logic [7:0] v);
        @(negedge clk_20mhz);
        loc_wr_en = 1'b1; loc_wr_idx = idx; loc_wr_data = v;
        @(negedge clk_20mhz);
        loc_wr_en = 1'b0;
    endtask

    initial begin
        reset_x = 1'b0; slot_x_int_x = 1'b0; clk_rw = 1'b0; ax_d = 1'b0; r_wx = 1'b0;
        data_in = 8'h00; loc_wr_en = 1'b0; loc_wr_idx = 3'd0; loc_wr_data = 8'h00; irq_set = 8'h00;
        wait_cyc(4);
        reset_x = 1'b1;
        wait_cyc(1);
        check("rst_oe",    {63'd0, data_oe_x}, 64'd1);
        check("rst_int",   {63'd0, int_x}, 64'd1);
        check("rst_int_oe",{63'd0, int_oe_x}, 64'd1);
        check("rst_regs",  regs_flat, 64'd0);
        check("rst_pulse", {63'd0, bus_wr_pulse}, 64'd0);
        check("rst_state", {61'd0, dbg_state}, 64'd0);

        // Card ID at address 0, then drive released
        bus_read(rd, oe_lo);
        check("id_data", {56'd0, rd}, 64'h68);
        check("id_oe",   {63'd0, oe_lo}, 64'd1);
        check("oe_rel",  {63'd0, data_oe_x}, 64'd1);

        // Address then three auto-incrementing writes
        bus_addr(8'h03);
        exp_q.push_back(8'd3); bus_write(8'hA5);
        exp_q.push_back(8'd4); bus_write(8'h5A);
        exp_q.push_back(8'd5); bus_write(8'h77);
        check("wr_idx3", {56'd0, regs_flat[31:24]}, 64'hA5);
        check("wr_idx4", {56'd0, regs_flat[39:32]}, 64'h5A);
        check("wr_idx5", {56'd0, regs_flat[47:40]}, 64'h77);

        // Wrap from the last index back to idx0
        bus_addr(8'h07);
        exp_q.push_back(8'd7); bus_write(8'hC3);
        bus_read(rd, oe_lo);
        check("wrap_after_wr", {56'd0, rd}, 64'h68);
        bus_addr(8'h07);
        bus_read(rd, oe_lo);
        check("rd_idx7", {56'd0, rd}, 64'hC3);
        bus_read(rd, oe_lo);
        check("rd_wrap", {56'd0, rd}, 64'h68);

        // Local port: idx0/idx1 protected, others writable
        loc_wr(3'd6, 8'h33);
        loc_wr(3'd1, 8'hFF);
        loc_wr(3'd0, 8'hFF);
        loc_wr(3'd2, 8'h04);
        check("loc_idx6", {56'd0, regs_flat[55:48]}, 64'h33);
        check("loc_idx1", {56'd0, regs_flat[15:8]}, 64'h00);
        check("loc_idx0", {56'd0, regs_flat[7:0]}, 64'h00);
        check("loc_mask", {56'd0, regs_flat[23:16]}, 64'h04);

        // Interrupt: registered one cycle after status sets
        irq_set = 8'h04;
        @(negedge clk_20mhz);
        irq_set = 8'h00;
        check("irq_status", {56'd0, regs_flat[15:8]}, 64'h04);
        check("irq_int_pre", {63'd0, int_x}, 64'd1);
        @(negedge clk_20mhz);
        check("irq_int",    {63'd0, int_x}, 64'd0);
        check("irq_int_oe", {63'd0, int_oe_x}, 64'd0);
        bus_addr(8'h01);
        bus_read(rd, oe_lo);
        check("irq_rd", {56'd0, rd}, 64'h04);
        check("irq_clr_int", {63'd0, int_x}, 64'd1);
        check("irq_clr_st",  {56'd0, regs_flat[15:8]}, 64'h00);

        // A bit raised during the read survives the clear
        irq_set = 8'h04;
        @(negedge clk_20mhz);
        irq_set = 8'h00;
        wait_cyc(2);
        check("irq2_int", {63'd0, int_x}, 64'd0);
        bus_addr(8'h01);
        bus_xfer(1'b0, 1'b1, 8'h00, 6, 4, 8'h04, 1'b0, rd, oe_lo);
        check("irq2_rd",  {56'd0, rd}, 64'h04);
        check("irq2_keep_int", {63'd0, int_x}, 64'd0);
        check("irq2_keep_st",  {56'd0, regs_flat[15:8]}, 64'h04);

        // Internal mode: bus ignored, pins released
        slot_x_int_x = 1'b1;
        wait_cyc(2);
        check("int_mode_int",    {63'd0, int_x}, 64'd1);
        check("int_mode_int_oe", {63'd0, int_oe_x}, 64'd1);
        bus_xfer(1'b0, 1'b1, 8'h00, 6, -1, 8'h00, 1'b0, rd, oe_lo);
        check("int_mode_oe", {63'd0, oe_lo}, 64'd0);
        slot_x_int_x = 1'b0;
        wait_cyc(2);
        check("slot_back_int", {63'd0, int_x}, 64'd0);
        bus_addr(8'h01);
        bus_read(rd, oe_lo);
        check("irq3_rd", {56'd0, rd}, 64'h04);
        check("irq3_int", {63'd0, int_x}, 64'd1);

        // Bus commit and local write to idx5 in the same cycle: bus wins
        loc_wr_idx = 3'd5; loc_wr_data = 8'h22;
        bus_addr(8'h05);
        exp_q.push_back(8'd5);
        bus_xfer(1'b0, 1'b0, 8'h11, 6, 2, 8'h00, 1'b1, rd, oe_lo);
        check("collide_idx5", {56'd0, regs_flat[47:40]}, 64'h11);

        // Strobe stuck high on a read of idx3
        bus_addr(8'h03);
        bus_xfer(1'b0, 1'b1, 8'h00, 1100, -1, 8'h00, 1'b0, rd, oe_lo);
`ifdef BKM_BUS_TIMEOUT_EN
        check("to_oe", {63'd0, oe_lo}, 64'd0);
        check("to_st7", {56'd0, regs_flat[15:8]}, 64'h80);
`else
        check("stuck_oe", {63'd0, oe_lo}, 64'd1);
        check("stuck_rd", {56'd0, rd}, 64'hA5);
        check("stuck_st7", {56'd0, regs_flat[15:8]}, 64'h00);
`endif
        bus_addr(8'h04);
        bus_read(rd, oe_lo);
        check("post_stuck_rd", {56'd0, rd}, 64'h5A);
        check("post_stuck_oe", {63'd0, oe_lo}, 64'd1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);

        reset_x = 1'b0;
        wait_cyc(2);
        reset_x = 1'b1;
        wait_cyc(1);
        check("rst2_regs", regs_flat, 64'd0);
        check("rst2_oe", {63'd0, data_oe_x}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bkm_bus_regfile.md
Name: bkm_bus_regfile

Overview:
- Parametrised successor to the single-function BKM-68X slot interface: a generic monitor-bus slave that maps NUM_REGS byte registers into the monitor's address space at BASE_ADDR.
- Adds address auto-increment, a local (FPGA-side) write port, a maskable interrupt status register and slot-mode gating.
- Sits between the slot pins (through the top-level wrapper) and the video/control logic.
- All bus inputs are asynchronous to clk_20mhz and are sampled through a synchroniser.

Parameters:
- NUM_REGS, 8, number of mapped registers (min 4, max 64)
- BASE_ADDR, 8'h00, first bus address of the register window
- CARD_ID, 8'h68, read-only value of register index 0
- SYNC_STAGES, 2, flip-flop stages on clk_rw (min 2)
- TIMEOUT_CYCLES, 1024, strobe-stuck limit (used only with the optional feature)

Ports:
- clk_20mhz  in  1  system clock
- reset_x  in  1  synchronous active-low reset
- slot_x_int_x  in  1  0 = slot mode (bus active), 1 = internal mode (bus ignored, outputs released)
- clk_rw  in  1  async bus strobe, idle low, transfer on high pulse
- ax_d  in  1  1 = address cycle, 0 = data cycle
- r_wx  in  1  1 = read, 0 = write
- data_in  in  8  bus data from monitor
- data_out  out  8  bus read data
- data_oe_x  out  1  active-low bus drive enable
- int_x  out  1  active-low interrupt
- int_oe_x  out  1  active-low interrupt drive enable
- loc_wr_en  in  1  local register write strobe
- loc_wr_idx  in  clog2(NUM_REGS)  local write index
- loc_wr_data  in  8  local write data
- irq_set  in  8  per-bit set pulses into status (index 1)
- regs_flat  out  NUM_REGS*8  all register contents; index i at bits [8i+7:8i]
- bus_wr_pulse  out  1  one-cycle pulse per committed bus write
- bus_wr_idx  out  clog2(NUM_REGS)  index of that write

Behaviour:
- Reset (reset_x=0 at clock edge) sets:
  - all registers, addr_q, data_out and the sync chain to 0
  - data_oe_x=1, int_x=1, int_oe_x=1, bus_wr_pulse=0
  - state=IDLE
  - Reset mid-transfer aborts the transfer and makes no register change.
- Synchroniser: strobe s = last stage of the SYNC_STAGES chain. Rise = s&~s_d; fall = ~s&s_d.
- Bus hold rule: ax_d, r_wx and data_in are sampled raw on the rise cycle. The bus must hold them stable while clk_rw is high, for at least SYNC_STAGES+2 clocks.
- Register map:
  - idx0 = CARD_ID, read-only; writes are ignored.
  - idx1 = IRQ status; bus writes are ignored; clear-on-read.
  - idx2 = IRQ mask.
  - idx3..NUM_REGS-1 = general read/write.
- Hit: addr_q in [BASE_ADDR, BASE_ADDR+NUM_REGS-1]; idx = addr_q-BASE_ADDR, computed in 8 bits.
- FSM IDLE -> ADDR / WRITE / READ on rise, selected by ax_d and r_wx:
  - ADDR: addr_q <= data_in; return to IDLE on fall.
  - WRITE: on the rise cycle+1, if hit, the register commits. bus_wr_pulse=1 and bus_wr_idx=idx for exactly that cycle, and regs_flat updates in the same cycle. Return to IDLE on fall.
  - READ: on the rise cycle+1, if hit, data_out=reg[idx] and data_oe_x=0; the presented value is latched. On fall cycle+1, data_oe_x=1, then IDLE. No hit means data_oe_x stays 1.
- Auto-increment: after every data-cycle fall, addr_q increments, hit or not. Past BASE_ADDR+NUM_REGS-1 it wraps to BASE_ADDR. Outside the window it increments mod 256.
- Clear-on-read of idx1: on fall, status <= (status & ~presented) | irq_set. A bit set during the read survives.
- Status update: status |= irq_set every cycle.
- Interrupt: int_x = ~|(status & mask), registered (1 cycle). int_oe_x = int_x, so the pin is driven only while asserting.
- Local writes: loc_wr_en writes loc_wr_idx in one cycle. It applies to idx2..NUM_REGS-1 only; other indices are ignored.
  - A bus commit to the same index in the same cycle wins and the local write is dropped.
  - A local write to an out-of-range index is ignored.
- Internal mode: when slot_x_int_x=1, the FSM is forced to IDLE and data_oe_x=int_oe_x=int_x=1. Registers hold and local writes still work. Switching mode mid-transfer aborts that transfer.

Optional Feature:
BKM_BUS_TIMEOUT_EN
- Defined: a counter runs while the FSM is in ADDR/WRITE/READ. When it reaches TIMEOUT_CYCLES:
  - the FSM returns to IDLE and data_oe_x=1;
  - status bit 7 is set;
  - the FSM then waits for s=0 before accepting the next rise.
- Undefined: no counter; the FSM waits indefinitely for fall; status bit 7 is set only by irq_set[7].

Test Plan:
- Reset -> data_oe_x=1, int_x=1, int_oe_x=1, regs_flat=0 (idx0 reads 8'h68 via bus).
- Address 8'h03, then write 8'hA5 and 8'h5A -> regs idx3=A5, idx4=5A; bus_wr_pulse twice with idx 3, 4; addr_q=05.
- NUM_REGS=8: address 8'h07, then read twice -> data 8'h(idx7) then 8'h68; the second read wraps to idx0.
- irq_set=8'h04 with mask idx2=8'h04 -> int_x=0 one cycle later; bus read of idx1 returns 8'h04; after fall, int_x=1. irq_set=8'h04 pulsed during the read -> int_x stays 0.
- Bus write 8'h11 and loc_wr_en write 8'h22 both to idx5 in the same cycle -> idx5=8'h11. slot_x_int_x=1 during a read strobe -> data_oe_x stays 1.
- With BKM_BUS_TIMEOUT_EN: clk_rw held high for 2000 clocks on a read -> data_oe_x=1 after 1024 clocks, status bit7=1, next transfer accepted only after clk_rw goes low.
